sprite_compositor: RTL and testbench

Parametrised per-pixel sprite compositor for the retro game video path, generalising the fixed dino/cactus/bird renderer to NUM_SPRITES generic slots. Game logic writes slots through a valid/ready config port into shadow registers, which become active together at frame_start. For each scanned pixel, the block performs:
- a bounds test against every active slot,
- two-level priority selection,
- a sheet address fetch on a 2-port sprite ROM with configurable latency,
- a composite of opaque sprite pixels over a background colour.

It also flags pixels that need redraw because they are covered in the current or the previous frame.

---
 rtl/sprite_compositor_if.sv | 50 +++++
 rtl/sprite_compositor.sv | 231 +++++++++++++++++++++++
 tb/tb_sprite_compositor.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_compositor_if.sv
// Bus bundle for sprite_compositor: slot config port, pixel request, ROM ports and result.
// The slave modport is the compositor; the master modport is the game/video/ROM side.
interface sprite_compositor_if #(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned SIZE_W      = 6,
    parameter int unsigned ADDR_W      = 14
);
    localparam int unsigned SLOT_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [SLOT_W-1:0]   cfg_slot;
    logic                cfg_enable;
    logic [COORD_W-1:0]  cfg_x;
    logic [COORD_W-1:0]  cfg_y;
    logic [SIZE_W-1:0]   cfg_w;
    logic [SIZE_W-1:0]   cfg_h;
    logic [ADDR_W-1:0]   cfg_base;
    logic                frame_start;
    logic                pix_valid;
    logic [COORD_W-1:0]  pix_x;
    logic [COORD_W-1:0]  pix_y;
    logic [14:0]         bg_rgb;
    logic [ADDR_W-1:0]   rom_addr_a;
    logic [ADDR_W-1:0]   rom_addr_b;
    logic [15:0]         rom_q_a;
    logic [15:0]         rom_q_b;
    logic                out_valid;
    logic [COORD_W-1:0]  out_x;
    logic [COORD_W-1:0]  out_y;
    logic [7:0]          out_r;
    logic [7:0]          out_g;
    logic [7:0]          out_b;
    logic                out_dirty;

    modport slave (
        input  cfg_valid, cfg_slot, cfg_enable, cfg_x, cfg_y, cfg_w, cfg_h, cfg_base,
        input  frame_start, pix_valid, pix_x, pix_y, bg_rgb, rom_q_a, rom_q_b,
        output cfg_ready, rom_addr_a, rom_addr_b,
        output out_valid, out_x, out_y, out_r, out_g, out_b, out_dirty
    );

    modport master (
        output cfg_valid, cfg_slot, cfg_enable, cfg_x, cfg_y, cfg_w, cfg_h, cfg_base,
        output frame_start, pix_valid, pix_x, pix_y, bg_rgb, rom_q_a, rom_q_b,
        input  cfg_ready, rom_addr_a, rom_addr_b,
        input  out_valid, out_x, out_y, out_r, out_g, out_b, out_dirty
    );
endinterface

// File: rtl/sprite_compositor.sv
// Per-pixel sprite compositor: shadow/active/prev slot banks, bounds test, two-level
// priority, dual-port sheet fetch and opaque-over-background composite with dirty flag.
module sprite_compositor #(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned SIZE_W      = 6,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned SHEET_W     = 512,
    parameter int unsigned ROM_LATENCY = 1
) (
    input logic                clock,
    input logic                reset,
    sprite_compositor_if.slave bus
);
    localparam int unsigned SLOT_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int unsigned SHEET_SH = $clog2(SHEET_W);
    localparam int unsigned CW1      = COORD_W + 1;

    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SIZE_W-1:0]  w;
        logic [SIZE_W-1:0]  h;
    } rect_t;

    typedef struct packed {
        rect_t              r;
        logic [ADDR_W-1:0]  base;
    } slot_t;

    typedef struct packed {
        logic               vld;
        logic [SIZE_W-1:0]  dx;
        logic [SIZE_W-1:0]  dy;
        logic [ADDR_W-1:0]  base;
    } sel_t;

    typedef struct packed {
        logic               vld;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [14:0]        bg;
        logic               a_vld;
        logic               b_vld;
        logic               dirty;
    } meta_t;

    slot_t r_sh [NUM_SPRITES];
    slot_t r_ac [NUM_SPRITES];
    rect_t r_pv [NUM_SPRITES];

    logic  w_slot_ok;
    slot_t w_cfg;

    assign bus.cfg_ready = !reset && !bus.frame_start;
    assign w_slot_ok     = ({1'b0, bus.cfg_slot} < (SLOT_W + 1)'(NUM_SPRITES));

    always_comb begin
        w_cfg        = '0;
        w_cfg.r.en   = bus.cfg_enable;
        w_cfg.r.x    = bus.cfg_x;
        w_cfg.r.y    = bus.cfg_y;
        w_cfg.r.w    = bus.cfg_w;
        w_cfg.r.h    = bus.cfg_h;
        w_cfg.base   = bus.cfg_base;
    end

    // cfg_ready is low during frame_start, so a write can never race the commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                r_sh[i] <= '0;
                r_ac[i] <= '0;
                r_pv[i] <= '0;
            end
        end else if (bus.frame_start) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                r_pv[i] <= r_ac[i].r;
                r_ac[i] <= r_sh[i];
            end
        end else if (bus.cfg_valid && w_slot_ok) begin
            r_sh[bus.cfg_slot] <= w_cfg;
        end
    end

    function automatic logic f_hit(rect_t s, logic [COORD_W-1:0] px, logic [COORD_W-1:0] py);
        logic [CW1-1:0] ex;
        logic [CW1-1:0] ey;
        ex = {1'b0, s.x} + CW1'(s.w);
        ey = {1'b0, s.y} + CW1'(s.h);
        return s.en && (px >= s.x) && ({1'b0, px} < ex) && (py >= s.y) && ({1'b0, py} < ey);
    endfunction

    function automatic logic [ADDR_W-1:0] f_addr(sel_t s);
        return s.vld ? s.base + (ADDR_W'(s.dy) << SHEET_SH) + ADDR_W'(s.dx) : '0;
    endfunction

    slot_t                  w_cur [NUM_SPRITES];
    rect_t                  w_old [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] w_hit;
    logic [NUM_SPRITES-1:0] w_phit;
    sel_t                   w_sel_a;
    sel_t                   w_sel_b;

    // A pixel arriving with frame_start sees the post-commit banks.
    always_comb begin
        w_hit   = '0;
        w_phit  = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            w_cur[i]  = bus.frame_start ? r_sh[i] : r_ac[i];
            w_old[i]  = bus.frame_start ? r_ac[i].r : r_pv[i];
            w_hit[i]  = bus.pix_valid && f_hit(w_cur[i].r, bus.pix_x, bus.pix_y);
            w_phit[i] = bus.pix_valid && f_hit(w_old[i], bus.pix_x, bus.pix_y);
            if (w_hit[i]) begin
                if (!w_sel_a.vld) begin
                    w_sel_a.vld  = 1'b1;
                    w_sel_a.dx   = SIZE_W'(bus.pix_x - w_cur[i].r.x);
                    w_sel_a.dy   = SIZE_W'(bus.pix_y - w_cur[i].r.y);
                    w_sel_a.base = w_cur[i].base;
                end else if (!w_sel_b.vld) begin
                    w_sel_b.vld  = 1'b1;
                    w_sel_b.dx   = SIZE_W'(bus.pix_x - w_cur[i].r.x);
                    w_sel_b.dy   = SIZE_W'(bus.pix_y - w_cur[i].r.y);
                    w_sel_b.base = w_cur[i].base;
                end
            end
        end
    end

    // Slot offsets are captured in S1 so a commit while the pixel is in flight cannot
    // change which slot geometry feeds its ROM address.
    logic               r_s1_vld;
    logic [COORD_W-1:0] r_s1_x;
    logic [COORD_W-1:0] r_s1_y;
    logic [14:0]        r_s1_bg;
    logic               r_s1_dirty;
    sel_t               r_s1_a;
    sel_t               r_s1_b;
    meta_t              r_s2;
    logic [ADDR_W-1:0]  r_rom_addr_a;
    logic [ADDR_W-1:0]  r_rom_addr_b;
    meta_t              r_dly [ROM_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_vld     <= 1'b0;
            r_s1_x       <= '0;
            r_s1_y       <= '0;
            r_s1_bg      <= '0;
            r_s1_dirty   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s2         <= '0;
            r_rom_addr_a <= '0;
            r_rom_addr_b <= '0;
            for (int unsigned k = 0; k < ROM_LATENCY; k++) begin
                r_dly[k] <= '0;
            end
        end else begin
            r_s1_vld     <= bus.pix_valid;
            r_s1_x       <= bus.pix_x;
            r_s1_y       <= bus.pix_y;
            r_s1_bg      <= bus.bg_rgb;
            r_s1_dirty   <= (|w_hit) || (|w_phit);
            r_s1_a       <= w_sel_a;
            r_s1_b       <= w_sel_b;
            r_s2         <= '{vld: r_s1_vld, x: r_s1_x, y: r_s1_y, bg: r_s1_bg,
                              a_vld: r_s1_a.vld, b_vld: r_s1_b.vld, dirty: r_s1_dirty};
            r_rom_addr_a <= f_addr(r_s1_a);
            r_rom_addr_b <= f_addr(r_s1_b);
            r_dly[0]     <= r_s2;
            for (int unsigned k = 1; k < ROM_LATENCY; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
        end
    end

    assign bus.rom_addr_a = r_rom_addr_a;
    assign bus.rom_addr_b = r_rom_addr_b;

    meta_t              w_last;
    logic [14:0]        w_rgb;
    logic               r_out_valid;
    logic [COORD_W-1:0] r_out_x;
    logic [COORD_W-1:0] r_out_y;
    logic [7:0]         r_out_r;
    logic [7:0]         r_out_g;
    logic [7:0]         r_out_b;
    logic               r_out_dirty;

    always_comb begin
        w_last = r_dly[ROM_LATENCY-1];
        w_rgb  = w_last.bg;
        if (w_last.a_vld && bus.rom_q_a[15]) begin
            w_rgb = bus.rom_q_a[14:0];
        end else if (w_last.b_vld && bus.rom_q_b[15]) begin
            w_rgb = bus.rom_q_b[14:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_r     <= '0;
            r_out_g     <= '0;
            r_out_b     <= '0;
            r_out_dirty <= 1'b0;
        end else begin
            r_out_valid <= w_last.vld;
            r_out_x     <= w_last.x;
            r_out_y     <= w_last.y;
            r_out_r     <= {w_rgb[14:10], 3'b000};
            r_out_g     <= {w_rgb[9:5], 3'b000};
            r_out_b     <= {w_rgb[4:0], 3'b000};
            r_out_dirty <= w_last.dirty;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_x     = r_out_x;
    assign bus.out_y     = r_out_y;
    assign bus.out_r     = r_out_r;
    assign bus.out_g     = r_out_g;
    assign bus.out_b     = r_out_b;
    assign bus.out_dirty = r_out_dirty;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: behavioural slot/ROM model feeds a scoreboard
// that the output monitor drains, checking colour, dirty, coordinates and exact latency.
module tb_sprite_compositor;
    localparam int NS    = 8;
    localparam int CW    = 11;
    localparam int SW    = 6;
    localparam int AW    = 14;
    localparam int SHEET = 512;
    localparam int LAT   = 1;

    logic clock = 1'b0;
    logic reset;

    sprite_compositor_if #(.NUM_SPRITES(NS), .COORD_W(CW), .SIZE_W(SW), .ADDR_W(AW)) bus ();

    sprite_compositor #(
        .NUM_SPRITES(NS), .COORD_W(CW), .SIZE_W(SW),
        .ADDR_W(AW), .SHEET_W(SHEET), .ROM_LATENCY(LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous one-cycle sprite ROM.
    logic [15:0] rom_mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        bus.rom_q_a <= rom_mem[bus.rom_addr_a];
        bus.rom_q_b <= rom_mem[bus.rom_addr_b];
    end

    typedef struct {
        logic en;
        int   x, y, w, h, base;
    } slot_t;

    typedef struct {
        int          x, y, r, g, b;
        logic        dirty;
        int unsigned cyc;
    } exp_t;

    slot_t m_sh [NS];
    slot_t m_ac [NS];
    slot_t m_pv [NS];
    exp_t  sb [$];
    exp_t  mon_e;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_out = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hit(slot_t s, int px, int py);
        return s.en && px >= s.x && px < s.x + s.w && py >= s.y && py < s.y + s.h;
    endfunction

    function automatic exp_t model(int px, int py, logic [14:0] bg);
        exp_t        e;
        int          a = -1;
        int          b = -1;
        logic        dirty = 1'b0;
        logic [14:0] c = bg;
        logic [15:0] q;
        for (int i = 0; i < NS; i++) begin
            if (m_hit(m_ac[i], px, py)) begin
                dirty = 1'b1;
                if (a < 0) a = i;
                else if (b < 0) b = i;
            end
            if (m_hit(m_pv[i], px, py)) dirty = 1'b1;
        end
        q = 16'h0;
        if (a >= 0) q = rom_mem[(m_ac[a].base + (py - m_ac[a].y) * SHEET + (px - m_ac[a].x)) & ((1 << AW) - 1)];
        if (a >= 0 && q[15]) begin
            c = q[14:0];
        end else if (b >= 0) begin
            q = rom_mem[(m_ac[b].base + (py - m_ac[b].y) * SHEET + (px - m_ac[b].x)) & ((1 << AW) - 1)];
            if (q[15]) c = q[14:0];
        end
        e.x = px; e.y = py;
        e.r = int'(c[14:10]) * 8;
        e.g = int'(c[9:5]) * 8;
        e.b = int'(c[4:0]) * 8;
        e.dirty = dirty;
        e.cyc = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic m_commit();
        for (int i = 0; i < NS; i++) begin
            m_pv[i] = m_ac[i];
            m_ac[i] = m_sh[i];
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_sh[i] = '{1'b0, 0, 0, 0, 0, 0};
            m_ac[i] = m_sh[i];
            m_pv[i] = m_sh[i];
        end
    endtask

    task automatic drive_pix(input int px, input int py, input logic [14:0] bg);
        exp_t e;
        bus.pix_valid = 1'b1;
        bus.pix_x = CW'(px);
        bus.pix_y = CW'(py);
        bus.bg_rgb = bg;
        e = model(px, py, bg);
        e.cyc = cyc + LAT + 3;
        sb.push_back(e);
        tick();
        bus.pix_valid = 1'b0;
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        m_commit();
    endtask

    task automatic cfg_write(input int s, input logic en, input int x, input int y,
                             input int w, input int h, input int base);
        logic acc = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_slot = 3'(s);
        bus.cfg_enable = en;
        bus.cfg_x = CW'(x); bus.cfg_y = CW'(y);
        bus.cfg_w = SW'(w); bus.cfg_h = SW'(h);
        bus.cfg_base = AW'(base);
        for (int t = 0; t < 10; t++) begin
            acc = bus.cfg_ready;
            tick();
            if (acc) break;
        end
        bus.cfg_valid = 1'b0;
        chk("cfg_accept", 32'(acc), 32'd1);
        if (acc) m_sh[s] = '{en, x, y, w, h, base};
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && sb.size() != 0; t++) tick();
        chk("drain", sb.size(), 0);
    endtask

    always @(negedge clock) begin
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                n_out++;
                chk("out_x", 32'(bus.out_x), mon_e.x);
                chk("out_y", 32'(bus.out_y), mon_e.y);
                chk("out_r", 32'(bus.out_r), mon_e.r);
                chk("out_g", 32'(bus.out_g), mon_e.g);
                chk("out_b", 32'(bus.out_b), mon_e.b);
                chk("out_dirty", 32'(bus.out_dirty), 32'(mon_e.dirty));
                chk("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg_slot = '0; bus.cfg_enable = 1'b0;
        bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_w = '0; bus.cfg_h = '0; bus.cfg_base = '0;
        bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
        bus.pix_x = '0; bus.pix_y = '0; bus.bg_rgb = '0;
        for (int k = 0; k < (1 << AW); k++) rom_mem[k] = 16'h0;
        m_reset();
        repeat (3) tick();

        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_x", 32'(bus.out_x), 0);
        chk("rst_out_y", 32'(bus.out_y), 0);
        chk("rst_out_rgb", {8'h0, bus.out_r, bus.out_g, bus.out_b}, 0);
        chk("rst_out_dirty", 32'(bus.out_dirty), 0);
        chk("rst_rom_addr_a", 32'(bus.rom_addr_a), 0);
        chk("rst_rom_addr_b", 32'(bus.rom_addr_b), 0);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 0);
        reset = 1'b0;
        tick();

        // 1: background only, latency
        drive_pix(10, 10, 15'h7FFF);
        drain();

        // 2: single sprite hit
        cfg_write(0, 1'b1, 64, 448, 32, 32, 0);
        rom_mem[1030] = 16'h801F;
        frame();
        drive_pix(70, 450, 15'h1234);
        tick();
        chk("t2_rom_addr_a", 32'(bus.rom_addr_a), 1030);
        chk("t2_rom_addr_b", 32'(bus.rom_addr_b), 0);
        drain();

        // 3: overlap, A transparent -> B; both transparent -> bg; A opaque wins
        cfg_write(1, 1'b1, 76, 456, 16, 16, 2000);
        frame();
        rom_mem[6160] = 16'h7FFF;
        rom_mem[4052] = 16'hFC00;
        drive_pix(80, 460, 15'h03E0);
        drain();
        rom_mem[4052] = 16'h7C00;
        drive_pix(80, 460, 15'h03E0);
        drain();
        rom_mem[6160] = 16'h83E0;
        rom_mem[4052] = 16'hFC00;
        drive_pix(80, 460, 15'h001F);
        drain();

        // 4: shadow commit and dirty
        cfg_write(0, 1'b1, 100, 448, 32, 32, 0);
        drive_pix(70, 450, 15'h0);
        drain();
        frame();
        drive_pix(70, 450, 15'h0);
        drain();
        bus.frame_start = 1'b1;
        m_commit();
        drive_pix(70, 450, 15'h0);
        bus.frame_start = 1'b0;
        drain();

        // 5: boundaries
        cfg_write(2, 1'b1, 2020, 100, 40, 8, 500);
        cfg_write(3, 1'b1, 5, 100, 0, 8, 700);
        rom_mem[4111] = 16'hC210;
        frame();
        drive_pix(5, 102, 15'h001F);
        drive_pix(2047, 107, 15'h001F);
        drain();

        bus.cfg_valid = 1'b1; bus.cfg_slot = 3'd4; bus.cfg_enable = 1'b1;
        bus.cfg_x = 11'd200; bus.cfg_y = 11'd200; bus.cfg_w = 6'd4; bus.cfg_h = 6'd4;
        bus.cfg_base = '0;
        bus.frame_start = 1'b1;
        #1;
        chk("cfg_ready_at_frame", 32'(bus.cfg_ready), 0);
        tick();
        m_commit();
        bus.frame_start = 1'b0;
        #1;
        chk("cfg_ready_after_frame", 32'(bus.cfg_ready), 1);
        tick();
        m_sh[4] = '{1'b1, 200, 200, 4, 4, 0};
        bus.cfg_valid = 1'b0;
        rom_mem[513] = 16'h801F;
        drive_pix(201, 201, 15'h0421);
        drain();
        frame();
        drive_pix(201, 201, 15'h0421);
        drain();

        // 6: streaming
        for (int k = 0; k < (1 << AW); k++) rom_mem[k] = 16'(k * 40503);
        n_out = 0;
        for (int i = 0; i < 100; i++) drive_pix(70 + i % 40, 445 + i / 5, 15'((i * 331) & 16'h7FFF));
        drain();
        chk("stream_count", n_out, 100);

        for (int i = 0; i < 50; i++) drive_pix(60 + i % 50, 450 + i / 7, 15'(i * 97));
        reset = 1'b1;
        tick();
        sb.delete();
        m_reset();
        chk("rst_flush_valid", 32'(bus.out_valid), 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (8) tick();
        drive_pix(10, 10, 15'h7FFF);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
